// File: rtl/alu_uart_interface.sv
// alu_uart_interface: sequences UART bytes into ALU operands A, B and OP, then returns the ALU result to the UART.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   i_rx_data/done : received byte and its one-cycle valid strobe
//   i_tx_done      : transmitter finished the current byte
//   i_alu_res      : ALU result, valid ALU_LAT edges after the operands settle
//   o_alu_a/b/op   : registered operands and opcode driven to the ALU
//   o_tx_data/start: result byte and its one-cycle transmit request
//   o_busy         : high whenever a frame is in progress
// Optional: define ALU_IF_TIMEOUT_EN to abandon a stalled frame after TIMEOUT_CYC idle cycles in WAIT_B/WAIT_OP.
module alu_uart_interface #(
  parameter int N_BITS      = 8,
  parameter int N_OP        = 6,
  parameter int ALU_LAT     = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_done,
  input  logic [N_BITS-1:0] i_alu_res,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [N_OP-1:0]   o_alu_op,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy
);
  localparam int CW = $clog2(ALU_LAT + 1) + 1;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, WAIT_RES, WAIT_TX} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N_BITS-1:0] r_alu_a, r_alu_b, r_tx_data;
  logic [N_OP-1:0] r_alu_op;
  logic r_tx_start;
  logic w_cnt_hit, w_timeout;
  assign w_cnt_hit = r_cnt == CW'(ALU_LAT);
`ifdef ALU_IF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle;
  assign w_timeout = r_idle == TW'(TIMEOUT_CYC);
  // Idle time only accumulates while waiting for B or OP; any byte or state change restarts it.
  always_ff @(posedge clock or posedge reset)
    if (reset) r_idle <= '0;
    else r_idle <= (i_rx_done || w_next != r_state || !(r_state == WAIT_B || r_state == WAIT_OP)) ? '0 : r_idle + TW'(1);
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:   w_next = i_rx_done ? WAIT_B : WAIT_A;
      WAIT_B:   w_next = i_rx_done ? WAIT_OP : (w_timeout ? WAIT_A : WAIT_B);
      WAIT_OP:  w_next = i_rx_done ? WAIT_RES : (w_timeout ? WAIT_A : WAIT_OP);
      WAIT_RES: w_next = w_cnt_hit ? WAIT_TX : WAIT_RES;
      WAIT_TX:  w_next = i_tx_done ? WAIT_A : WAIT_TX;
      default:  w_next = WAIT_A;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state    <= WAIT_A;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= 1'b0;
      if (r_state == WAIT_A && i_rx_done) r_alu_a <= i_rx_data;
      if (r_state == WAIT_B && i_rx_done) r_alu_b <= i_rx_data;
      if (r_state == WAIT_OP && i_rx_done) begin
        r_alu_op <= i_rx_data[N_OP-1:0];
        r_cnt    <= '0;
      end
      // Result is sampled once the ALU has had ALU_LAT edges on the new opcode.
      if (r_state == WAIT_RES) begin
        if (w_cnt_hit) begin
          r_tx_data  <= i_alu_res;
          r_tx_start <= 1'b1;
        end else r_cnt <= r_cnt + CW'(1);
      end
    end
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_state != WAIT_A;
endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface: table-driven and scoreboarded bench for alu_uart_interface with a registered ALU model.
module tb_alu_uart_interface;
  localparam int LAT = 1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] i_rx_data = '0;
  logic i_rx_done = 1'b0, i_tx_done = 1'b0;
  logic [7:0] i_alu_res;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic o_tx_start, o_busy;
  int checks = 0, errors = 0;
  int cyc = 0, op_cyc = 0;
  logic prev_start = 1'b0;
  logic [7:0] q[$];

  alu_uart_interface #(.N_BITS(8), .N_OP(6), .ALU_LAT(LAT), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .reset(reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_res(i_alu_res), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Registered ALU: one edge of latency, MIPS-style function codes.
  always @(posedge clock)
    case (o_alu_op)
      6'h20:   i_alu_res <= o_alu_a + o_alu_b;
      6'h22:   i_alu_res <= o_alu_a - o_alu_b;
      6'h24:   i_alu_res <= o_alu_a & o_alu_b;
      6'h25:   i_alu_res <= o_alu_a | o_alu_b;
      6'h26:   i_alu_res <= o_alu_a ^ o_alu_b;
      6'h27:   i_alu_res <= ~(o_alu_a | o_alu_b);
      6'h02:   i_alu_res <= o_alu_a >> o_alu_b;
      default: i_alu_res <= 8'h00;
    endcase

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (o_tx_start) begin
      chk("tx_start_width", {31'b0, prev_start}, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_start_unexpected: got start with data %0h, expected no start", o_tx_data);
      end else begin
        chk("tx_data", o_tx_data, q.pop_front());
        chk("tx_latency", cyc - op_cyc, LAT + 1);
      end
    end
    prev_start = o_tx_start;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clock);
    i_rx_done = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] res, input logic [5:0] eop);
    int n;
    send(a);
    send(b);
    send(op);
    op_cyc = cyc;
    q.push_back(res);
    chk("alu_op", o_alu_op, eop);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL tx_start_timeout: got no start in 20 cycles, expected data %0h", res);
      q.delete();
    end
    chk("busy_in_tx", o_busy, 1);
  endtask

  task automatic tx_ack();
    @(negedge clock);
    i_tx_done = 1'b1;
    @(negedge clock);
    i_tx_done = 1'b0;
    chk("busy_after_tx", o_busy, 0);
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_a", o_alu_a, 0);
    chk("rst_b", o_alu_b, 0);
    chk("rst_op", o_alu_op, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b, op, res;
    logic [5:0] eop;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 6'h22};
    vecs[2] = '{8'h80, 8'h03, 8'hC2, 8'h10, 6'h02};
    vecs[3] = '{8'hF0, 8'h3C, 8'h24, 8'h30, 6'h24};
    vecs[4] = '{8'hFF, 8'h0F, 8'h26, 8'hF0, 6'h26};
    vecs[5] = '{8'h0F, 8'hF0, 8'h27, 8'h00, 6'h27};
    vecs[6] = '{8'hFF, 8'h02, 8'h20, 8'h01, 6'h20};
    vecs[7] = '{8'h01, 8'h01, 8'h25, 8'h01, 6'h25};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_busy", o_busy, 0);
    // Asynchronous reset mid-frame, then A capture.
    send(8'h55);
    chk("a_before_rst", o_alu_a, 8'h55);
    mid_reset();
    send(8'h11);
    chk("a_after_rst", o_alu_a, 8'h11);
    chk("busy_wait_b", o_busy, 1);
    mid_reset();
    // Table of complete frames.
    for (int i = 0; i < 8; i++) begin
      frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].eop);
      tx_ack();
    end
    // Bytes during WAIT_RES and WAIT_TX are dropped.
    send(8'h05);
    send(8'h03);
    send(8'h20);
    op_cyc = cyc;
    q.push_back(8'h08);
    send(8'h66);
    chk("a_rx_in_res", o_alu_a, 8'h05);
    repeat (3) @(negedge clock);
    chk("q_drained", q.size(), 0);
    send(8'h7F);
    chk("a_rx_in_tx", o_alu_a, 8'h05);
    repeat (8) @(negedge clock);
    chk("busy_hold_tx", o_busy, 1);
    tx_ack();
    // Simultaneous rx and tx strobes in WAIT_TX: return to WAIT_A, byte dropped.
    frame(8'h09, 8'h04, 8'h22, 8'h05, 6'h22);
    @(negedge clock);
    i_rx_data = 8'h99;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    @(negedge clock);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    chk("busy_both_strobes", o_busy, 0);
    chk("a_both_strobes", o_alu_a, 8'h09);
    frame(8'h01, 8'h01, 8'h25, 8'h01, 6'h25);
    tx_ack();
    // Reset in WAIT_OP discards the partial frame.
    send(8'h0A);
    // tx_done outside WAIT_TX is ignored.
    @(negedge clock);
    i_tx_done = 1'b1;
    @(negedge clock);
    i_tx_done = 1'b0;
    chk("busy_tx_done_ignored", o_busy, 1);
    send(8'h0B);
    chk("b_captured", o_alu_b, 8'h0B);
    mid_reset();
    frame(8'h02, 8'h02, 8'h20, 8'h04, 6'h20);
    tx_ack();
    // Stalled frame: timeout only with the optional feature.
    send(8'h33);
`ifdef ALU_IF_TIMEOUT_EN
    repeat (20) @(negedge clock);
    chk("busy_timeout", o_busy, 0);
    chk("a_kept_timeout", o_alu_a, 8'h33);
`else
    repeat (100) @(negedge clock);
    chk("busy_no_timeout", o_busy, 1);
    send(8'h04);
    send(8'h22);
    op_cyc = cyc;
    q.push_back(8'h2F);
    repeat (5) @(negedge clock);
    chk("q_drained_late", q.size(), 0);
    tx_ack();
`endif
    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Command sequencer that drives the registered ALU operand/opcode inputs and returns its result. It consumes a byte stream from the UART receiver and captures A, B and OP in that order. It waits out the ALU's registered latency, then hands the result byte to the UART transmitter. It sits between uart_rx/uart_tx and the ALU in the board top level.

Parameters:
N_BITS, 8, width of operands A/B, received bytes, the ALU result and the transmitted byte.
N_OP, 6, width of the opcode driven to the ALU; taken from the low N_OP bits of the OP byte.
ALU_LAT, 1, clock edges the ALU needs after o_alu_op changes before i_alu_res is valid (≥1).
TIMEOUT_CYC, 1000000, idle-cycle limit for the optional frame timeout.

Ports:
clock  input  1  system clock, all logic on its rising edge
reset  input  1  asynchronous, active-high reset
i_rx_data  input  N_BITS  byte from UART receiver
i_rx_done  input  1  one-cycle strobe: i_rx_data valid this cycle
i_tx_done  input  1  one-cycle strobe: transmitter finished the current byte
i_alu_res  input  N_BITS  ALU result
o_alu_a  output  N_BITS  operand A to ALU
o_alu_b  output  N_BITS  operand B to ALU
o_alu_op  output  N_OP  opcode to ALU
o_tx_data  output  N_BITS  result byte to transmitter
o_tx_start  output  1  one-cycle strobe requesting transmission of o_tx_data
o_busy  output  1  high whenever state ≠ WAIT_A

Behaviour:
- Reset (asynchronous, active-high; clock is clock):
  - All outputs go to 0.
  - State goes to WAIT_A and the latency counter clears.
  - Reset mid-frame discards all partial captures; the first i_rx_done after release is treated as A.
- States and transitions:
  - WAIT_A: on i_rx_done, o_alu_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[N_OP-1:0] (upper bits discarded); cnt <= 0; go to WAIT_RES.
  - WAIT_RES: each edge with cnt ≠ ALU_LAT does cnt <= cnt+1. On the edge where cnt == ALU_LAT: o_tx_data <= i_alu_res, o_tx_start <= 1, go to WAIT_TX.
  - WAIT_TX: o_tx_start is cleared the edge after it was set, so it is exactly one cycle wide. On i_tx_done go to WAIT_A.
- Latency: o_tx_start rises ALU_LAT+1 edges after the edge that captured OP. With ALU_LAT=1 that is 2 edges.
- o_alu_a/b/op hold their last captured values until overwritten. The ALU keeps recomputing on these values, which is harmless.
- i_rx_done in WAIT_RES or WAIT_TX is ignored: the byte is dropped and no operand changes.
- i_tx_done outside WAIT_TX is ignored.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: return to WAIT_A; the rx byte is dropped, not captured as A.
- No arithmetic is performed here. Result width equals N_BITS, passed through unchanged.

Optional Feature:
- Macro ALU_IF_TIMEOUT_EN.
- Defined:
  - An idle counter runs in WAIT_B and WAIT_OP and clears on every i_rx_done and on every state change.
  - When it reaches TIMEOUT_CYC, state returns to WAIT_A. Captured operands are retained but the frame restarts.
  - WAIT_RES and WAIT_TX are not timed.
- Not defined: no counter logic exists; the block waits indefinitely for the next byte.

Test Plan:
1. Assert reset mid-cycle → all outputs 0 immediately (asynchronous), o_busy=0; release, then send 0x11 → o_alu_a=0x11.
2. Send bytes 0x05, 0x03, 0x20 with a bench ALU model (ADD, ALU_LAT=1) → o_alu_op=6'b100000. o_tx_start is high for exactly one cycle, 2 edges after the OP edge, with o_tx_data=0x08. Pulse i_tx_done → o_busy=0.
3. Send 0x03, 0x05, 0x22 (SUB) → o_tx_data=0xFE. Then send 0xC2 as OP in a new frame → o_alu_op=6'b000010.
4. During WAIT_TX, strobe i_rx_done with 0x7F → o_alu_a unchanged, no second o_tx_start. Next frame 0x01, 0x01, 0x25 (OR) → o_tx_data=0x01.
5. Send A=0x0A, B=0x0B, then assert reset in WAIT_OP → outputs 0. Next bytes 0x02, 0x02, 0x20 → o_tx_data=0x04.
6. With ALU_IF_TIMEOUT_EN and TIMEOUT_CYC=16: send A only, idle 16 cycles → o_busy falls to 0. Without the macro, o_busy stays 1 after 100 cycles.
